// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths and the buffered load entry type for the write-back stage
package regbank_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regbank_writeback_if.sv
// regbank_writeback_if: ALU/load result inputs and register bank write port of the write-back stage
interface regbank_writeback_if
  import regbank_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] wAddr;
  logic              regWriteFlag;
  logic [NREG-1:0]   pending_mask;
  logic [CW-1:0]     fifo_count;
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, wrData, wAddr, regWriteFlag, pending_mask, fifo_count
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output ld_ready, wrData, wAddr, regWriteFlag, pending_mask, fifo_count
  );
endinterface

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: compacted load-result queue with squash-by-address, count and pending mask
module wb_load_fifo
  import regbank_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              sq_i,
  input  logic [ADDR_W-1:0] sq_addr_i,
  output wb_entry_t         head_o,
  output logic [CW-1:0]     count_o,
  output logic [NREG-1:0]   pending_o
);
  wb_entry_t e_q [DEPTH];
  wb_entry_t e_d [DEPTH];
  logic [CW-1:0] n;
  // survivors slide toward slot 0 in age order, so slot 0 is always the oldest entry
  always_comb begin
    e_d = '{default: '0};
    n = '0;
    for (int i = 0; i < DEPTH; i++)
      if (e_q[i].valid && !(pop_i && i == 0) && !(sq_i && e_q[i].addr == sq_addr_i)) begin
        e_d[n[IW-1:0]] = e_q[i];
        n = n + CW'(1);
      end
    if (push_i) e_d[n[IW-1:0]] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
  end
  // entry storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) e_q <= '{default: '0};
    else e_q <= e_d;
  // occupancy and per-register pending bits derived from stored entries only
  always_comb begin
    count_o = '0;
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_o = count_o + CW'(e_q[i].valid);
      if (e_q[i].valid) pending_o[e_q[i].addr] = 1'b1;
    end
  end
  assign head_o = e_q[0];
endmodule

// File: rtl/regbank_writeback.sv
// regbank_writeback: arbitrates ALU results and buffered/bypassed loads onto the register write port
module regbank_writeback
  import regbank_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  regbank_writeback_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  wb_entry_t head;
  logic [CW-1:0] count;
  logic alu_w, ld_acc, pop, byp, push;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  assign bus.ld_ready = rst_n && (count < FULL);
  // priority: ALU, then FIFO head, then bypass of a fresh load; a load colliding with the ALU target is older and dropped
  always_comb begin
    ld_acc = bus.ld_valid && bus.ld_ready;
    alu_w = bus.alu_valid && bus.alu_addr != REG_ZERO;
    pop = !alu_w && head.valid;
    byp = !alu_w && !head.valid && ld_acc && bus.ld_addr != REG_ZERO;
    push = ld_acc && bus.ld_addr != REG_ZERO && !byp && !(alu_w && bus.ld_addr == bus.alu_addr);
    wr_en_d = alu_w || pop || byp;
    wr_addr_d = alu_w ? bus.alu_addr : pop ? head.addr : byp ? bus.ld_addr : wr_addr_q;
    wr_data_d = alu_w ? bus.alu_data : pop ? head.data : byp ? bus.ld_data : wr_data_q;
  end
  // registered write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  wb_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_addr_i (bus.ld_addr),
    .push_data_i (bus.ld_data),
    .pop_i       (pop),
    .sq_i        (alu_w),
    .sq_addr_i   (bus.alu_addr),
    .head_o      (head),
    .count_o     (count),
    .pending_o   (bus.pending_mask)
  );
  assign bus.fifo_count = count;
  assign bus.regWriteFlag = wr_en_q;
  assign bus.wAddr = wr_addr_q;
  assign bus.wrData = wr_data_q;
endmodule

// File: tb/tb_regbank_writeback.sv
// tb_regbank_writeback: directed and random checks against a queue-based write-back model
module tb_regbank_writeback;
  localparam int D = 2;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regbank_writeback_if #(.FIFO_DEPTH(D)) bus ();
  regbank_writeback #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  ent_t q[$];
  logic ewr = 1'b0;
  logic [4:0] ewa = '0;
  logic [31:0] ewd = '0;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_outputs();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    chk("flag", 64'(bus.regWriteFlag), 64'(ewr));
    chk("waddr", 64'(bus.wAddr), 64'(ewa));
    chk("wdata", 64'(bus.wrData), 64'(ewd));
    chk("count", 64'(bus.fifo_count), 64'(q.size()));
    chk("pending", 64'(bus.pending_mask), 64'(m));
  endtask
  // drive one cycle of inputs, predict the result from queue semantics, then check after the edge
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit acc;
    ent_t keep[$];
    ent_t h;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ld;
    #1;
    chk("ld_ready", 64'(bus.ld_ready), 64'(q.size() < D));
    acc = lv && (q.size() < D);
    ewr = 1'b0;
    if (av && aa != 0) begin
      ewr = 1'b1; ewa = aa; ewd = ad;
      foreach (q[i]) if (q[i].a != aa) keep.push_back(q[i]);
      q = keep;
      if (la == aa) acc = 1'b0;
    end else if (q.size() != 0) begin
      h = q.pop_front();
      ewr = 1'b1; ewa = h.a; ewd = h.d;
    end else if (acc && la != 0) begin
      ewr = 1'b1; ewa = la; ewd = ld;
      acc = 1'b0;
    end
    if (acc && la != 0) q.push_back('{a: la, d: ld});
    @(posedge clk);
    #1;
    chk_outputs();
  endtask
  initial begin
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_ld_ready", 64'(bus.ld_ready), 64'(1));
    chk_outputs();
    @(posedge clk);
    #1;
    // bypass of a lone load
    step(0, 0, 0, 1, 3, 32'hDEADBEEF);
    chk("byp_addr", 64'(bus.wAddr), 64'(3));
    chk("byp_data", 64'(bus.wrData), 64'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("byp_one_cycle", 64'(bus.regWriteFlag), 64'(0));
    // contention: ALU r5 for three cycles while loads to 6 and 7 wait
    step(1, 5, 32'h11, 1, 6, 32'h66);
    step(1, 5, 32'h11, 1, 7, 32'h77);
    chk("cont_mask67", 64'(bus.pending_mask), 64'h0C0);
    step(1, 5, 32'h11, 1, 8, 32'h88);
    step(0, 0, 0, 0, 0, 0);
    chk("cont_pop6", 64'(bus.wAddr), 64'(6));
    chk("cont_mask7", 64'(bus.pending_mask), 64'h080);
    step(0, 0, 0, 0, 0, 0);
    chk("cont_pop7", 64'(bus.wAddr), 64'(7));
    step(0, 0, 0, 0, 0, 0);
    // squash: buffered r9 killed by a younger ALU write to r9
    step(1, 1, 32'h1, 1, 9, 32'hAAAA);
    chk("sq_pend9", 64'(bus.pending_mask), 64'h200);
    step(1, 9, 32'h55, 0, 0, 0);
    chk("sq_data", 64'(bus.wrData), 64'h55);
    chk("sq_count", 64'(bus.fifo_count), 64'(0));
    step(0, 0, 0, 0, 0, 0);
    // register 0 on both paths
    step(1, 0, 32'h77, 1, 0, 32'h88);
    chk("r0_noflag", 64'(bus.regWriteFlag), 64'(0));
    // randomized traffic on a narrow address range to provoke collisions
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset with a full FIFO and a strobe in flight
    step(1, 1, 32'h10, 1, 2, 32'h20);
    step(1, 1, 32'h11, 1, 3, 32'h30);
    chk("pre_rst_full", 64'(bus.fifo_count), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flag", 64'(bus.regWriteFlag), 64'(0));
    chk("mid_rst_count", 64'(bus.fifo_count), 64'(0));
    chk("mid_rst_ready", 64'(bus.ld_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    ewr = 1'b0; ewa = '0; ewd = '0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
- Write-back stage that drives the register bank write port (wrData, wAddr, regWriteFlag).
- Merges two result sources into that single write port:
  - the single-cycle ALU result path, which has priority and cannot be stalled;
  - the multi-cycle load-return path, which uses a valid/ready handshake.
- Buffers load results in a small squashable FIFO and publishes a per-register pending mask so issue logic can stall on outstanding loads.

Parameters:
- DATA_W, 32, width of a register/result word
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 2, number of buffered load results (power of two, at least 2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle (always accepted)
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- wrData  out  DATA_W  to register bank wrData
- wAddr  out  ADDR_W  to register bank wAddr
- regWriteFlag  out  1  one-cycle write strobe to register bank
- pending_mask  out  2**ADDR_W  bit r set while a load for register r is buffered
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered entry count

Behaviour:
- Reset (asynchronous, rst_n low):
  - wrData=0, wAddr=0, regWriteFlag=0;
  - FIFO empty, fifo_count=0, pending_mask=0;
  - ld_ready is forced to 0 while rst_n is low.
- ld_ready = rst_n && (fifo_count < FIFO_DEPTH).
  - Depends on registered state only; no combinational path from ld_valid or alu_valid.
  - A pop in the same cycle does not raise ld_ready.
- Write-port outputs are registered: a selected write appears on wrData/wAddr/regWriteFlag the cycle after selection. regWriteFlag is high for exactly one cycle per write.
- Selection each cycle, in priority order:
  1. alu_valid && alu_addr!=0: ALU write.
  2. Otherwise, FIFO non-empty: pop the head and write it.
  3. Otherwise, accepted load with ld_addr!=0: bypass it straight to the write port, with no FIFO entry.
  4. Otherwise, regWriteFlag=0 next cycle; wrData/wAddr hold their previous values.
- Accepted load not written this cycle:
  - pushed at the tail if ld_addr!=0;
  - loads to register 0 are accepted and discarded.
- ALU writes to register 0 are ignored (no strobe).
- Ordering rule: a load is always older than a concurrent ALU result.
  - A committed ALU write to register R invalidates every buffered load entry with addr R, in the same edge.
  - It also discards an incoming accepted load with ld_addr==R.
  - Invalidated entries are removed from fifo_count and pending_mask on that edge; they never reach the write port.
  - Remaining entries keep FIFO order.
- pending_mask is registered. Bit r = OR over valid entries with addr r. Bypassed loads never set a bit.
- Simultaneous push and pop is allowed when the FIFO is not full; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation drops all buffered entries and any in-flight strobe immediately.

Decomposition:
- Package regbank_pkg holds:
  - DATA_W, ADDR_W, REG_ZERO=0;
  - typedef wb_entry_t {valid, addr, data}.
- Sub-module wb_load_fifo:
  - entry array, push/pop, squash-by-address compare and compaction;
  - count and pending_mask generation.
- The top level holds only arbitration and the output registers.

Test Plan:
- Reset release, no traffic -> regWriteFlag=0, ld_ready=1, pending_mask=0, fifo_count=0.
- Bypass: load only, ld_addr=3, ld_data=0xDEADBEEF, FIFO empty -> next cycle wAddr=3, wrData=0xDEADBEEF, regWriteFlag=1 for 1 cycle; fifo_count stays 0.
- Contention: alu_valid with addr=5, data=0x11 for 3 cycles, while loads to 6 and 7 are presented:
  - strobes for 5,5,5, then 6, then 7;
  - ld_ready drops after 2 accepts;
  - pending_mask bits 6 and 7 are set, then clear in pop order.
- Squash: FIFO holds load r9 (0xAAAA), then ALU write r9=0x55 -> only the r9=0x55 strobe occurs; fifo_count 1->0; pending_mask[9] clears on the same edge.
- Register 0: alu_addr=0 and ld_addr=0 -> no strobe, load accepted (ld_ready stays 1), FIFO stays empty.
- Reset mid-operation: FIFO full plus a strobe in flight, pulse rst_n low -> regWriteFlag falls immediately, FIFO empty after release, no stale write follows.
